irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Parametrised Wishbone-mapped interrupt controller; next generation of the single-mode edge IRQ register.
- Adds per-channel edge/level mode, per-channel polarity, software set, and a priority CLAIM register returning the highest-priority pending channel.
- Sits on the data bus beside the other peripherals; drives the single CPU irq line.

Parameters:
- ADDR, 0, peripheral select value compared against wb_dbus_adr[31:32-ADDR_W].
- ADDR_W, 8, width of the peripheral select field.
- N_IRQ, 8, channel count, legal range 1..31.

Ports:
- wb_clk  input  1  clock.
- wb_rst  input  1  reset; synchronous, active-high.
- wb_dbus_adr  input  32  bus address. [31:32-ADDR_W] selects the block; [5:2] selects the register.
- wb_dbus_dat  input  32  write data; bits [N_IRQ-1:0] are used.
- wb_dbus_we  input  1  write enable.
- wb_dbus_cyc  input  1  bus cycle.
- ack  output  1  one-cycle access acknowledge.
- rdt  output  32  read data; zero except during a read ack.
- irq_in  input  N_IRQ  raw interrupt sources.
- irq  output  1  CPU interrupt request.
- claim_id  output  5  index of the highest-priority active channel; 0 when none.

Behaviour:
- sel = wb_dbus_cyc & (wb_dbus_adr[31:32-ADDR_W]==ADDR). stb = sel & !ack.
- ack is a register: it is loaded with stb, so it is high for exactly the cycle after stb. One ack per access; the master drops cyc after ack.
- Writes and read side effects take place on the stb cycle. Read data is registered on the stb cycle and driven on rdt while ack & !wb_dbus_we. Otherwise rdt=0. Unused upper bits read 0.
- Conditioned input: c = irq_in ^ POL.
- Edge detect: rise = c & ~prev; prev <= c every cycle.
- Register map, by adr[5:2]:
  - 0 ENABLE, read/write.
  - 1 PENDING, read only. Returns the pend register for edge channels and c for level channels.
  - 2 PEND_CLR, write-1-clear. Acts on edge channels only.
  - 3 RAW, read only. Returns c.
  - 4 EN_SET, write-1-set.
  - 5 EN_CLR, write-1-clear.
  - 6 MODE, read/write. Bit=1 means level, bit=0 means edge.
  - 7 POL, read/write. Bit=1 inverts the input (active-low / falling edge).
  - 8 CLAIM, read only. Returns {bit31=valid, [4:0]=index}. Reading it clears the pend bit of the returned channel if that channel is edge-mode.
  - 9 PEND_SET, write-1-set. Software trigger; acts on edge channels only.
  - 10..15: reads return 0; writes are ignored.
- Edge channels:
  - pend bit sets on rise regardless of ENABLE, so an edge that arrives while disabled is held.
  - Set sources are rise and PEND_SET. Clear sources are PEND_CLR and the CLAIM read.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Level channels: the active value is c. The pend flop is held at 0.
- Active vector: act = pend_eff & ENABLE. irq = |act, combinational from registers.
- Priority: the lowest index has the highest priority. claim_id = index+1 of the lowest set bit of act; 0 when act==0.
- CLAIM read: returns the claim_id in effect on the stb cycle. valid = (claim_id!=0). index = claim_id-1 when valid, 0 when not valid.
- Writing POL or MODE updates prev using the new c on the next cycle. A polarity change may produce one edge.
- Reset, synchronous on wb_rst:
  - ENABLE, MODE, POL, pend and the read data register all go to 0.
  - prev <= irq_in, so no spurious edge is seen after reset.
  - ack=0, rdt=0, irq=0.
  - A reset asserted during an access aborts it; no ack is issued.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irq_in passes through a two-flop synchronizer (reset 0) before polarity and edge logic. Input-to-pend latency is 3 cycles.
- Not defined: irq_in is used directly. Input-to-pend latency is 1 cycle. Sources must already be synchronous to wb_clk.

Test Plan:
- Reset, write ENABLE=0x05, edge mode. Pulse irq_in[2] for one cycle -> PENDING=0x04, irq=1, claim_id=3. Write PEND_CLR=0x04 -> irq=0.
- Enable channels 1 and 3 (0x0A); raise both edges in the same cycle -> CLAIM read returns 0x80000001. A second CLAIM read returns 0x80000003. A third returns 0x00000000 and irq=0.
- Set MODE=0x01, POL=0x01, ENABLE=0x01; drive irq_in[0]=0 -> irq=1. Write PEND_CLR=0x01 -> irq stays 1. Drive irq_in[0]=1 -> irq=0.
- With ENABLE=0, pulse irq_in[4] -> irq=0, PENDING=0x10. Write EN_SET=0x10 -> irq=1 on the next cycle.
- In the same cycle as a rising edge on channel 0, write PEND_CLR=0x01 -> pend[0] remains 1.
- Read address 12 -> rdt=0 for the ack cycle, ack high for exactly 1 cycle. Assert wb_rst during stb -> no ack; all registers read 0 afterwards.

Source files
------------

// File: rtl/irq_ctrl.sv
// Wishbone-mapped interrupt controller: per-channel edge/level mode, polarity, software set, priority CLAIM.
// Optional macro IRQ_SYNC_EN adds a two-flop input synchronizer ahead of the polarity/edge logic.
module irq_ctrl #(
  parameter int unsigned ADDR   = 0,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned N_IRQ  = 8
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [31:0]      wb_dbus_adr,
  input  logic [31:0]      wb_dbus_dat,
  input  logic             wb_dbus_we,
  input  logic             wb_dbus_cyc,
  output logic             ack,
  output logic [31:0]      rdt,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq,
  output logic [4:0]       claim_id
);
  localparam logic [ADDR_W-1:0] SEL_VAL = ADDR_W'(ADDR);
  localparam int unsigned PAD = 32 - N_IRQ;

  logic             ack_reg;
  logic [31:0]      rd_data_reg;
  logic [N_IRQ-1:0] enable_reg, mode_reg, pol_reg, pend_reg, prev_reg;
  logic [N_IRQ-1:0] pend_next, irq_src, cond, rise, pend_eff, act;
  logic [N_IRQ-1:0] wdat;
  logic [3:0]       reg_idx;
  logic             sel, stb, wr, rd, claim_rd;
  logic [31:0]      rd_word;
  logic             unused_bits;

  assign sel     = wb_dbus_cyc & (wb_dbus_adr[31:32-ADDR_W] == SEL_VAL);
  assign stb     = sel & ~ack_reg;
  assign wr      = stb & wb_dbus_we;
  assign rd      = stb & ~wb_dbus_we;
  assign reg_idx = wb_dbus_adr[5:2];
  assign wdat    = wb_dbus_dat[N_IRQ-1:0];
  assign claim_rd = rd & (reg_idx == 4'd8);
  assign unused_bits = ^{wb_dbus_adr, wb_dbus_dat};

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_reg, sync2_reg;
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq_in;
      sync2_reg <= sync1_reg;
    end
  end
  assign irq_src = sync2_reg;
`else
  assign irq_src = irq_in;
`endif

  assign cond     = irq_src ^ pol_reg;
  assign rise     = cond & ~prev_reg;
  // Level channels report the conditioned input directly; their pend flop stays 0.
  assign pend_eff = (pend_reg & ~mode_reg) | (cond & mode_reg);
  assign act      = pend_eff & enable_reg;
  assign irq      = |act;

  always_comb begin
    claim_id = 5'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (act[i]) claim_id = 5'(i + 1);
    end
  end

  // Set beats clear when both hit the same bit in one cycle.
  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
    logic set_b, clr_b;
    assign set_b = ~mode_reg[gi] & (rise[gi] | (wr & (reg_idx == 4'd9) & wdat[gi]));
    assign clr_b = (wr & (reg_idx == 4'd2) & wdat[gi]) | (claim_rd & (claim_id == 5'(gi + 1)));
    assign pend_next[gi] = ~mode_reg[gi] & (set_b | (pend_reg[gi] & ~clr_b));
  end

  always_comb begin
    rd_word = 32'd0;
    case (reg_idx)
      4'd0: rd_word = {{PAD{1'b0}}, enable_reg};
      4'd1: rd_word = {{PAD{1'b0}}, pend_eff};
      4'd3: rd_word = {{PAD{1'b0}}, cond};
      4'd6: rd_word = {{PAD{1'b0}}, mode_reg};
      4'd7: rd_word = {{PAD{1'b0}}, pol_reg};
      4'd8: rd_word = (claim_id != 5'd0) ? {1'b1, 26'd0, claim_id - 5'd1} : 32'd0;
      default: rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_reg     <= 1'b0;
      rd_data_reg <= 32'd0;
      enable_reg  <= '0;
      mode_reg    <= '0;
      pol_reg     <= '0;
      pend_reg    <= '0;
      prev_reg    <= irq_in;
    end else begin
      ack_reg  <= stb;
      pend_reg <= pend_next;
      prev_reg <= cond;
      if (rd) rd_data_reg <= rd_word;
      if (wr) begin
        case (reg_idx)
          4'd0: enable_reg <= wdat;
          4'd4: enable_reg <= enable_reg | wdat;
          4'd5: enable_reg <= enable_reg & ~wdat;
          4'd6: mode_reg   <= wdat;
          4'd7: pol_reg    <= wdat;
          default: ;
        endcase
      end
    end
  end

  assign ack = ack_reg;
  assign rdt = (ack_reg & ~wb_dbus_we) ? rd_data_reg : 32'd0;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (default build, N_IRQ=8, ADDR=0).
module tb_irq_ctrl;
  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [31:0] wb_dbus_adr = 32'd0;
  logic [31:0] wb_dbus_dat = 32'd0;
  logic        wb_dbus_we = 1'b0;
  logic        wb_dbus_cyc = 1'b0;
  logic        ack;
  logic [31:0] rdt;
  logic [7:0]  irq_in = 8'd0;
  logic        irq;
  logic [4:0]  claim_id;

  int total = 0;
  int bad = 0;
  logic [31:0] q;

  irq_ctrl #(.ADDR(0), .ADDR_W(8), .N_IRQ(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_dbus_adr(wb_dbus_adr), .wb_dbus_dat(wb_dbus_dat),
    .wb_dbus_we(wb_dbus_we), .wb_dbus_cyc(wb_dbus_cyc), .ack(ack), .rdt(rdt),
    .irq_in(irq_in), .irq(irq), .claim_id(claim_id)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // One bus access with a bounded wait for ack, followed by one idle cycle.
  task automatic bus(input logic [3:0] r, input logic w, input logic [31:0] d, output logic [31:0] data);
    int n;
    wb_dbus_adr = {26'd0, r, 2'b00};
    wb_dbus_we  = w;
    wb_dbus_dat = d;
    wb_dbus_cyc = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk); #1;
      n++;
    end while (!ack && n < 4);
    if (!ack) check("ack_timeout", {31'd0, ack}, 32'd1);
    data = rdt;
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
    @(posedge wb_clk); #1;
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    bus(r, 1'b1, d, dummy);
  endtask

  task automatic do_reset();
    wb_dbus_cyc = 1'b0;
    irq_in = 8'd0;
    wb_rst = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1 wb_rst = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_in = m;
    @(posedge wb_clk); #1;
    irq_in = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_claim", {27'd0, claim_id}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdt", rdt, 32'd0);

    // Edge pend on channel 2, then clear.
    wr(4'd0, 32'h05);
    pulse(8'h04);
    bus(4'd1, 1'b0, 0, q); check("pending_ch2", q, 32'h04);
    check("irq_ch2", {31'd0, irq}, 32'd1);
    check("claim_id_ch2", {27'd0, claim_id}, 32'd3);
    wr(4'd2, 32'h04);
    check("irq_after_clr", {31'd0, irq}, 32'd0);

    // Two simultaneous edges, claimed in priority order.
    wr(4'd0, 32'h0A);
    irq_in = 8'h0A;
    @(posedge wb_clk); #1;
    bus(4'd8, 1'b0, 0, q); check("claim1", q, 32'h80000001);
    bus(4'd8, 1'b0, 0, q); check("claim2", q, 32'h80000003);
    bus(4'd8, 1'b0, 0, q); check("claim3", q, 32'h00000000);
    check("irq_after_claims", {31'd0, irq}, 32'd0);

    // Active-low level channel 0.
    do_reset();
    wr(4'd6, 32'h01);
    wr(4'd7, 32'h01);
    wr(4'd0, 32'h01);
    check("level_irq_on", {31'd0, irq}, 32'd1);
    wr(4'd2, 32'h01);
    check("level_irq_after_clr", {31'd0, irq}, 32'd1);
    irq_in[0] = 1'b1;
    @(posedge wb_clk); #1;
    check("level_irq_off", {31'd0, irq}, 32'd0);

    // Edge held while disabled, then enabled; software set and EN_CLR.
    do_reset();
    pulse(8'h10);
    check("disabled_irq", {31'd0, irq}, 32'd0);
    bus(4'd1, 1'b0, 0, q); check("disabled_pending", q, 32'h10);
    wr(4'd4, 32'h10);
    check("en_set_irq", {31'd0, irq}, 32'd1);
    wr(4'd9, 32'h40);
    bus(4'd1, 1'b0, 0, q); check("pend_set", q, 32'h50);
    bus(4'd0, 1'b0, 0, q); check("en_set_value", q, 32'h10);
    wr(4'd5, 32'h10);
    check("en_clr_irq", {31'd0, irq}, 32'd0);

    // Rising edge and PEND_CLR in the same cycle: set wins.
    do_reset();
    wr(4'd0, 32'h01);
    irq_in[0] = 1'b1;
    wb_dbus_adr = {26'd0, 4'd2, 2'b00}; wb_dbus_we = 1'b1; wb_dbus_dat = 32'h01; wb_dbus_cyc = 1'b1;
    @(posedge wb_clk); #1;
    wb_dbus_cyc = 1'b0; wb_dbus_we = 1'b0;
    @(posedge wb_clk); #1;
    bus(4'd1, 1'b0, 0, q); check("set_wins_pending", q, 32'h01);
    check("set_wins_claim_id", {27'd0, claim_id}, 32'd1);

    // Unmapped read: zero data, single-cycle ack.
    wr(4'd0, 32'hFF);
    wb_dbus_adr = {26'd0, 4'd12, 2'b00}; wb_dbus_we = 1'b0; wb_dbus_cyc = 1'b1;
    @(posedge wb_clk); #1;
    check("adr12_ack", {31'd0, ack}, 32'd1);
    check("adr12_rdt", rdt, 32'd0);
    wb_dbus_cyc = 1'b0;
    @(posedge wb_clk); #1;
    check("adr12_ack_drop", {31'd0, ack}, 32'd0);

    // Reset during stb aborts the access and clears all state.
    irq_in = 8'd0;
    wr(4'd6, 32'h0F);
    wr(4'd7, 32'h0F);
    bus(4'd3, 1'b0, 0, q); check("raw_inverted", q, 32'h0F);
    wb_dbus_adr = {26'd0, 4'd0, 2'b00}; wb_dbus_we = 1'b1; wb_dbus_dat = 32'hFF; wb_dbus_cyc = 1'b1;
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    check("rst_abort_ack", {31'd0, ack}, 32'd0);
    wb_dbus_cyc = 1'b0; wb_dbus_we = 1'b0;
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;
    check("rst_abort_ack2", {31'd0, ack}, 32'd0);
    bus(4'd0, 1'b0, 0, q); check("post_rst_enable", q, 32'h0);
    bus(4'd6, 1'b0, 0, q); check("post_rst_mode", q, 32'h0);
    bus(4'd7, 1'b0, 0, q); check("post_rst_pol", q, 32'h0);
    bus(4'd1, 1'b0, 0, q); check("post_rst_pending", q, 32'h0);
    check("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
